pfu: RTL and testbench

Prefetch unit for the rv32i core. Issues sequential 32-bit instruction fetches to the instruction memory port, buffers returned words in a small in-order FIFO, and presents them to the id stage over the dav/ack fetch interface. On a vector request from the ex stage it flushes the buffer, discards in-flight responses and restarts fetching at the new address, tagging the first delivered instruction.

---
 rtl/pfu_pkg.sv | 26 ++
 rtl/pfu_fifo.sv | 61 ++++++
 rtl/pfu.sv | 170 +++++++++++++++++
 tb/tb_pfu.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pfu_pkg.sv
// Shared types for the pfu prefetch unit, plus the sofid encoding shared with the id stage.
// Optional misaligned-vector trapping is enabled by defining PFU_MISALIGN_CHK_EN.
`ifndef SOFID_RANGE
`define SOFID_RANGE 1:0
`endif
`ifndef SOFID_1ST
`define SOFID_1ST 2'b01
`endif
`ifndef SOFID_RUN
`define SOFID_RUN 2'b00
`endif

package pfu_pkg;

  typedef struct packed {
    logic [31:0]           ins;
    logic                  ferr;
    logic [31:0]           pc;
    logic [`SOFID_RANGE]   sofid;
  } pfu_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pfu_fifo.sv
// Small in-order synchronous FIFO with flush; Depth must be a power of two.
module pfu_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (en_i) begin
      if (flush_i) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (do_push) begin
          mem_q[wr_q] <= wdata_i;
          wr_q        <= wr_q + AddrW'(1);
        end
        if (do_pop) begin
          rd_q <= rd_q + AddrW'(1);
        end
        cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
      end
    end
  end

endmodule

// File: rtl/pfu.sv
// Prefetch unit: sequential instruction fetch, in-order buffering, vector flush/discard.
// Define PFU_MISALIGN_CHK_EN to turn misaligned vector targets into a single ferr entry.
module pfu
  import pfu_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic                clk_i,
  input  logic                clk_en_i,
  input  logic                resetb_i,
  output logic                ireq_valid_o,
  input  logic                ireq_ready_i,
  output logic [31:0]         ireq_addr_o,
  input  logic                irsp_valid_i,
  input  logic [31:0]         irsp_data_i,
  input  logic                irsp_err_i,
  input  logic                exs_vec_i,
  input  logic [31:0]         exs_vec_addr_i,
  output logic                ids_dav_o,
  input  logic                ids_ack_i,
  output logic [`SOFID_RANGE] ids_sofid_o,
  output logic [31:0]         ids_ins_o,
  output logic                ids_ferr_o,
  output logic [31:0]         ids_pc_o
);

  // out_q counts every request still owed a response, to-be-dropped ones included, so it
  // can exceed DEPTH while discarding; the 2*DEPTH cap bounds it across repeated vectors.
  localparam int unsigned CntW = $clog2(2 * DEPTH + 1);
  localparam int unsigned FcW  = $clog2(DEPTH) + 1;

  logic [31:0]     fa_q, fa_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] out_q, out_d;
  logic [CntW-1:0] dis_q, dis_d;
  logic            first_q, first_d;
  logic            run_q, run_d;
`ifdef PFU_MISALIGN_CHK_EN
  logic            halt_q, halt_d;
  logic            mis_q, mis_d;
`endif

  logic [FcW-1:0]  fifo_cnt;
  logic            fifo_full, fifo_empty;
  logic            req_hs, rsp_drop, rsp_live;
  logic            push, pop;
  logic [CntW:0]   used;
  pfu_entry_t      push_entry, head;

  assign used = (CntW+1)'(fifo_cnt) + (CntW+1)'(out_q) - (CntW+1)'(dis_q);

  assign ireq_valid_o = run_q & (used < (CntW+1)'(DEPTH)) & (out_q < CntW'(2 * DEPTH));
  assign ireq_addr_o  = fa_q;
  assign req_hs       = ireq_valid_o & ireq_ready_i;
  assign rsp_drop     = irsp_valid_i & (dis_q != '0);
  assign rsp_live     = irsp_valid_i & (dis_q == '0);

  always_comb begin
    fa_d       = fa_q;
    rsp_pc_d   = rsp_pc_q;
    dis_d      = dis_q;
    first_d    = first_q;
    run_d      = 1'b1;
    push       = 1'b0;
    pop        = ~fifo_empty & ids_ack_i;
    push_entry = '{ins: irsp_data_i, ferr: irsp_err_i, pc: rsp_pc_q,
                   sofid: (first_q ? `SOFID_1ST : `SOFID_RUN)};
`ifdef PFU_MISALIGN_CHK_EN
    halt_d     = halt_q;
    mis_d      = 1'b0;
`endif

    out_d = out_q + CntW'(req_hs) - CntW'(irsp_valid_i);
    if (req_hs) begin
      fa_d = fa_q + 32'd4;
    end
    if (rsp_drop) begin
      dis_d = dis_q - CntW'(1);
    end
    if (rsp_live) begin
      push     = 1'b1;
      first_d  = 1'b0;
      rsp_pc_d = rsp_pc_q + 32'd4;
    end

`ifdef PFU_MISALIGN_CHK_EN
    run_d = ~halt_q;
    if (mis_q) begin
      push       = 1'b1;
      first_d    = 1'b0;
      push_entry = '{ins: 32'h0, ferr: 1'b1, pc: rsp_pc_q, sofid: `SOFID_1ST};
    end
`endif

    if (exs_vec_i) begin
      push     = 1'b0;
      pop      = 1'b0;
      // Everything still owed, including this cycle's request, is now stale.
      dis_d    = out_d;
      fa_d     = word_align(exs_vec_addr_i);
      rsp_pc_d = word_align(exs_vec_addr_i);
      first_d  = 1'b1;
`ifdef PFU_MISALIGN_CHK_EN
      if (exs_vec_addr_i[1:0] != 2'b00) begin
        halt_d   = 1'b1;
        mis_d    = 1'b1;
        rsp_pc_d = exs_vec_addr_i;
      end else begin
        halt_d   = 1'b0;
      end
      run_d = ~halt_d;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fa_q     <= RESET_ADDR;
      rsp_pc_q <= RESET_ADDR;
      out_q    <= '0;
      dis_q    <= '0;
      first_q  <= 1'b1;
      run_q    <= 1'b0;
`ifdef PFU_MISALIGN_CHK_EN
      halt_q   <= 1'b0;
      mis_q    <= 1'b0;
`endif
    end else if (clk_en_i) begin
      fa_q     <= fa_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      dis_q    <= dis_d;
      first_q  <= first_d;
      run_q    <= run_d;
`ifdef PFU_MISALIGN_CHK_EN
      halt_q   <= halt_d;
      mis_q    <= mis_d;
`endif
    end
  end

  pfu_fifo #(
    .Width ($bits(pfu_entry_t)),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (resetb_i),
    .en_i    (clk_en_i),
    .flush_i (exs_vec_i),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Credit accounting must never let a push land on a full, non-draining FIFO.
  assert property (@(posedge clk_i) disable iff (!resetb_i)
                   !(clk_en_i && push && fifo_full && !pop && !exs_vec_i));

  assign ids_dav_o   = ~fifo_empty;
  assign ids_ins_o   = head.ins;
  assign ids_ferr_o  = head.ferr;
  assign ids_pc_o    = head.pc;
  assign ids_sofid_o = head.sofid;

endmodule

// File: tb/tb_pfu.sv
// Scoreboard bench for pfu: directed scenarios feed an expected queue, a monitor checks pops.
module tb_pfu;

  logic                clk_i = 1'b0;
  logic                clk_en_i;
  logic                resetb_i;
  logic                ireq_valid_o;
  logic                ireq_ready_i;
  logic [31:0]         ireq_addr_o;
  logic                irsp_valid_i;
  logic [31:0]         irsp_data_i;
  logic                irsp_err_i;
  logic                exs_vec_i;
  logic [31:0]         exs_vec_addr_i;
  logic                ids_dav_o;
  logic                ids_ack_i;
  logic [`SOFID_RANGE] ids_sofid_o;
  logic [31:0]         ids_ins_o;
  logic                ids_ferr_o;
  logic [31:0]         ids_pc_o;

  pfu #(
    .DEPTH      (4),
    .RESET_ADDR (32'h0)
  ) dut (
    .clk_i          (clk_i),
    .clk_en_i       (clk_en_i),
    .resetb_i       (resetb_i),
    .ireq_valid_o   (ireq_valid_o),
    .ireq_ready_i   (ireq_ready_i),
    .ireq_addr_o    (ireq_addr_o),
    .irsp_valid_i   (irsp_valid_i),
    .irsp_data_i    (irsp_data_i),
    .irsp_err_i     (irsp_err_i),
    .exs_vec_i      (exs_vec_i),
    .exs_vec_addr_i (exs_vec_addr_i),
    .ids_dav_o      (ids_dav_o),
    .ids_ack_i      (ids_ack_i),
    .ids_sofid_o    (ids_sofid_o),
    .ids_ins_o      (ids_ins_o),
    .ids_ferr_o     (ids_ferr_o),
    .ids_pc_o       (ids_pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]         pc;
    logic [31:0]         ins;
    logic                ferr;
    logic [`SOFID_RANGE] sofid;
  } sb_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  sb_t         exp_q[$];
  mreq_t       mq[$];
  logic [31:0] req_log[$];
  int          checks    = 0;
  int          errors    = 0;
  int          delivered = 0;
  int          lat       = 1;
  logic [31:0] err_addr  = 32'hFFFF_FFFC;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic exp_push(input logic [31:0] pc, input logic [31:0] ins, input logic ferr,
                          input logic first);
    sb_t x;
    x.pc    = pc;
    x.ins   = ins;
    x.ferr  = ferr;
    x.sofid = first ? `SOFID_1ST : `SOFID_RUN;
    exp_q.push_back(x);
  endtask

  // Waits for the monitor to see `target` deliveries, leaving ack untouched.
  task automatic run_until(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (delivered < target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(delivered), 32'(target));
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    resetb_i  = 1'b0;
    exs_vec_i = 1'b0;
    ids_ack_i = 1'b0;
    #1;
    check("rst_req_valid", 32'(ireq_valid_o), 32'h0);
    check("rst_dav", 32'(ids_dav_o), 32'h0);
    check("rst_addr", ireq_addr_o, 32'h0);
    check("rst_ins", ids_ins_o, 32'h0);
    tick(2);
    req_log.delete();
    delivered = 0;
    resetb_i  = 1'b1;
  endtask

  // Memory model: fixed latency, in order, no backpressure on responses.
  initial begin : mem_model
    int e;
    e = 0;
    irsp_valid_i = 1'b0;
    irsp_data_i  = '0;
    irsp_err_i   = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!resetb_i) begin
        mq.delete();
      end else if (ireq_valid_o && ireq_ready_i && clk_en_i) begin
        mq.push_back('{addr: ireq_addr_o, due: e + 1 + lat});
        req_log.push_back(ireq_addr_o);
      end
      @(posedge clk_i);
      e++;
      #1;
      if (resetb_i && mq.size() != 0 && mq[0].due <= e + 1) begin
        irsp_valid_i = 1'b1;
        irsp_data_i  = mq[0].addr + 32'h1000_0000;
        irsp_err_i   = (mq[0].addr == err_addr);
        void'(mq.pop_front());
      end else begin
        irsp_valid_i = 1'b0;
        irsp_data_i  = '0;
        irsp_err_i   = 1'b0;
      end
    end
  end

  initial begin : monitor
    sb_t x;
    forever begin
      @(negedge clk_i);
      if (resetb_i && clk_en_i && ids_dav_o && ids_ack_i && !exs_vec_i) begin
        delivered++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got pc %h, want no entry", ids_pc_o);
        end else begin
          x = exp_q.pop_front();
          check("sb_pc", ids_pc_o, x.pc);
          check("sb_ins", ids_ins_o, x.ins);
          check("sb_ferr", 32'(ids_ferr_o), 32'(x.ferr));
          check("sb_sofid", 32'(ids_sofid_o), 32'(x.sofid));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin : stim
    clk_en_i       = 1'b1;
    resetb_i       = 1'b0;
    ireq_ready_i   = 1'b1;
    exs_vec_i      = 1'b0;
    exs_vec_addr_i = '0;
    ids_ack_i      = 1'b0;

    // Zero-wait memory, continuous ack.
    lat = 1;
    do_reset();
    ids_ack_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      exp_push(32'(4 * i), 32'h1000_0000 + 32'(4 * i), 1'b0, i == 0);
    end
    tick();
    check("s1_first_valid", 32'(ireq_valid_o), 32'h1);
    check("s1_first_addr", ireq_addr_o, 32'h0);
    tick();
    check("s1_dav_early", 32'(ids_dav_o), 32'h0);
    tick();
    check("s1_dav_rise", 32'(ids_dav_o), 32'h1);
    tick(7);
    ids_ack_i = 1'b0;
    check("s1_throughput", 32'(delivered), 32'd7);
    check("s1_req_count", 32'(req_log.size()), 32'd9);
    check("s1_req0", req_log[0], 32'h0);
    check("s1_req1", req_log[1], 32'h4);
    check("s1_req2", req_log[2], 32'h8);
    check("s1_req3", req_log[3], 32'hC);
    check("s1_drain", 32'(exp_q.size()), 32'h0);

    // Id stall: credit stops at DEPTH, one ack frees exactly one request.
    do_reset();
    tick(10);
    check("s2_req_count", 32'(req_log.size()), 32'd4);
    check("s2_req3", req_log[3], 32'hC);
    check("s2_valid_off", 32'(ireq_valid_o), 32'h0);
    check("s2_dav", 32'(ids_dav_o), 32'h1);
    exp_push(32'h0, 32'h1000_0000, 1'b0, 1'b1);
    ids_ack_i = 1'b1;
    tick();
    ids_ack_i = 1'b0;
    tick(4);
    check("s2_req_count2", 32'(req_log.size()), 32'd5);
    check("s2_req4", req_log[4], 32'h10);
    check("s2_valid_off2", 32'(ireq_valid_o), 32'h0);
    check("s2_drain", 32'(exp_q.size()), 32'h0);

    // Vector with 3 outstanding, latency 3.
    lat = 3;
    do_reset();
    ids_ack_i = 1'b1;
    exp_push(32'h100, 32'h1000_0100, 1'b0, 1'b1);
    exp_push(32'h104, 32'h1000_0104, 1'b0, 1'b0);
    exp_push(32'h108, 32'h1000_0108, 1'b0, 1'b0);
    tick(3);
    exs_vec_i      = 1'b1;
    exs_vec_addr_i = 32'h100;
    tick();
    exs_vec_i = 1'b0;
    check("s3_vec_valid", 32'(ireq_valid_o), 32'h1);
    check("s3_vec_addr", ireq_addr_o, 32'h100);
    check("s3_dav", 32'(ids_dav_o), 32'h0);
    run_until(3, 40, "s3_delivered");
    ids_ack_i = 1'b0;
    check("s3_req_old", req_log[2], 32'h8);
    check("s3_req_new", req_log[3], 32'h100);
    check("s3_drain", 32'(exp_q.size()), 32'h0);

    // Vector, ack and response all in the same cycle.
    lat = 1;
    do_reset();
    ids_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_push(32'(4 * i), 32'h1000_0000 + 32'(4 * i), 1'b0, i == 0);
    end
    run_until(4, 40, "s4_pre");
    check("s4_rsp_present", 32'(irsp_valid_i), 32'h1);
    exs_vec_i      = 1'b1;
    exs_vec_addr_i = 32'h200;
    exp_push(32'h200, 32'h1000_0200, 1'b0, 1'b1);
    exp_push(32'h204, 32'h1000_0204, 1'b0, 1'b0);
    exp_push(32'h208, 32'h1000_0208, 1'b0, 1'b0);
    tick();
    exs_vec_i = 1'b0;
    check("s4_flushed", 32'(ids_dav_o), 32'h0);
    check("s4_vec_valid", 32'(ireq_valid_o), 32'h1);
    check("s4_vec_addr", ireq_addr_o, 32'h200);
    run_until(7, 40, "s4_post");
    ids_ack_i = 1'b0;
    check("s4_drain", 32'(exp_q.size()), 32'h0);

    // Bus error at 0x8; fetching carries on.
    err_addr = 32'h8;
    do_reset();
    ids_ack_i = 1'b1;
    exp_push(32'h0, 32'h1000_0000, 1'b0, 1'b1);
    exp_push(32'h4, 32'h1000_0004, 1'b0, 1'b0);
    exp_push(32'h8, 32'h1000_0008, 1'b1, 1'b0);
    exp_push(32'hC, 32'h1000_000C, 1'b0, 1'b0);
    exp_push(32'h10, 32'h1000_0010, 1'b0, 1'b0);
    run_until(5, 40, "s5_delivered");
    ids_ack_i = 1'b0;
    err_addr  = 32'hFFFF_FFFC;
    check("s5_drain", 32'(exp_q.size()), 32'h0);

    // Misaligned vector target.
    do_reset();
    ids_ack_i = 1'b1;
    tick();
    exs_vec_i      = 1'b1;
    exs_vec_addr_i = 32'h102;
    tick();
    exs_vec_i = 1'b0;
`ifdef PFU_MISALIGN_CHK_EN
    check("s6_no_req", 32'(ireq_valid_o), 32'h0);
    exp_push(32'h102, 32'h0, 1'b1, 1'b1);
    run_until(1, 10, "s6_delivered");
    ids_ack_i = 1'b0;
    tick(3);
    check("s6_req_count", 32'(req_log.size()), 32'd1);
    check("s6_still_off", 32'(ireq_valid_o), 32'h0);
`else
    check("s6_valid", 32'(ireq_valid_o), 32'h1);
    check("s6_addr", ireq_addr_o, 32'h100);
    exp_push(32'h100, 32'h1000_0100, 1'b0, 1'b1);
    run_until(1, 10, "s6_delivered");
    ids_ack_i = 1'b0;
    check("s6_req_new", req_log[1], 32'h100);
`endif
    check("s6_drain", 32'(exp_q.size()), 32'h0);

    do_reset();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
